// File: rtl/ram_stream_pkg.sv
// Shared types and sizing helpers for the RAM stream reader.
package ram_stream_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN
   } state_t;

   // Bits needed to hold a count from 0 up to and including max_val.
   function automatic int cnt_w(input int max_val);
      return $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/ram_stream_reader_fifo.sv
// Show-ahead FIFO: head word visible while not empty; push and pop in one cycle keep occupancy.
// Zero-latency head; a push into a full FIFO is only legal together with a pop.
module stream_fifo
   import ram_stream_pkg::*;
#(
   parameter int WIDTH = 33,
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    push_i,
   input  logic [WIDTH-1:0]        push_dat_i,
   input  logic                    pop_i,
   output logic [WIDTH-1:0]        head_dat_o,
   output logic                    empty_o,
   output logic [cnt_w(DEPTH)-1:0] count_o
);

   localparam int CW = cnt_w(DEPTH);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    rd_ptr_q;
   logic [PW-1:0]    wr_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign do_pop  = pop_i && (count_q != '0);
   assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
   end

   // Head is forced to zero when empty so stale storage never shows on the outputs.
   assign empty_o    = (count_q == '0);
   assign head_dat_o = empty_o ? '0 : mem_q[rd_ptr_q];
   assign count_o    = count_q;

   a_no_overflow: assert property (@(posedge clk) disable iff (reset)
      !(push_i && (count_q == CW'(DEPTH)) && !pop_i));

endmodule

// File: rtl/ram_stream_reader.sv
// Issues sequential reads to a fixed-latency RAM and streams the words out with a last marker.
// First word LATENCY+1 cycles after the first issue; issue is credit-limited so backpressure never drops data.
module ram_stream_reader
   import ram_stream_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int ADDR_WIDTH = 10,
   parameter int LATENCY    = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [ADDR_WIDTH-1:0] cmd_base,
   input  logic [ADDR_WIDTH:0]   cmd_count,
   output logic                  ram_clken,
   output logic                  ram_read_en,
   output logic                  ram_write_en,
   output logic [ADDR_WIDTH-1:0] ram_address,
   output logic [WIDTH/8-1:0]    ram_byte_en,
   output logic [WIDTH-1:0]      ram_write_data,
   input  logic [WIDTH-1:0]      ram_read_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDTH-1:0]      out_data,
   output logic                  out_last,
   output logic                  busy,
   output logic                  done
);

   localparam int FCW = cnt_w(FIFO_DEPTH);
   localparam int ICW = cnt_w(LATENCY);
   localparam logic [ADDR_WIDTH:0] REM_ONE = 1;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH:0]   rem_q, rem_d;
   logic [LATENCY-1:0]    vld_sr_q, vld_sr_d;
   logic [LATENCY-1:0]    last_sr_q, last_sr_d;
   logic                  zero_done_q, zero_done_d;
   logic                  last_seen_q, last_seen_d;

   logic [ICW-1:0]        inflight;
   logic [FCW-1:0]        fifo_cnt;
   logic                  fifo_empty;
   logic [WIDTH:0]        head_dat;
   logic                  pop;
   logic                  issue;
   logic                  credit_ok;

   assign out_valid = !fifo_empty;
   assign out_data  = head_dat[WIDTH-1:0];
   assign out_last  = head_dat[WIDTH];
   assign pop       = out_valid && out_ready;

   always_comb begin
      inflight = '0;
      for (int i = 0; i < LATENCY; i++) inflight = inflight + ICW'(vld_sr_q[i]);
   end

   // A slot freed by this cycle's pop is immediately reusable by this cycle's issue.
   assign credit_ok = (32'(inflight) + 32'(fifo_cnt)) < (32'(FIFO_DEPTH) + 32'(pop));

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      rem_d       = rem_q;
      zero_done_d = 1'b0;
      last_seen_d = last_seen_q || (pop && out_last);
      issue       = 1'b0;
      cmd_ready   = 1'b0;
      done        = zero_done_q;
      case (state_q)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               addr_d      = cmd_base;
               rem_d       = cmd_count;
               last_seen_d = 1'b0;
               if (cmd_count == '0) zero_done_d = 1'b1;
               else                 state_d     = ISSUE;
            end
         end
         ISSUE: begin
            if (credit_ok) begin
               issue  = 1'b1;
               addr_d = addr_q + ADDR_WIDTH'(1);
               rem_d  = rem_q - REM_ONE;
               if (rem_q == REM_ONE) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if ((inflight == '0) && fifo_empty && last_seen_q) begin
               done    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      vld_sr_d     = vld_sr_q;
      last_sr_d    = last_sr_q;
      vld_sr_d[0]  = issue;
      last_sr_d[0] = issue && (rem_q == REM_ONE);
      for (int i = 1; i < LATENCY; i++) begin
         vld_sr_d[i]  = vld_sr_q[i-1];
         last_sr_d[i] = last_sr_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         rem_q       <= '0;
         vld_sr_q    <= '0;
         last_sr_q   <= '0;
         zero_done_q <= 1'b0;
         last_seen_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         rem_q       <= rem_d;
         vld_sr_q    <= vld_sr_d;
         last_sr_q   <= last_sr_d;
         zero_done_q <= zero_done_d;
         last_seen_q <= last_seen_d;
      end
   end

   stream_fifo #(
      .WIDTH (WIDTH + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push_i     (vld_sr_q[LATENCY-1]),
      .push_dat_i ({last_sr_q[LATENCY-1], ram_read_data}),
      .pop_i      (pop),
      .head_dat_o (head_dat),
      .empty_o    (fifo_empty),
      .count_o    (fifo_cnt)
   );

   assign ram_clken      = 1'b1;
   assign ram_read_en    = issue;
   assign ram_write_en   = 1'b0;
   assign ram_address    = addr_q;
   assign ram_byte_en    = '0;
   assign ram_write_data = '0;
   assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench: DUT A (LATENCY=1, depth 2) for exact timing, DUT B (LATENCY=3, depth 4) for wrap,
// backpressure, reset and back-to-back commands. RAM models return mem[i]=i after LATENCY cycles.
module tb_ram_stream_reader;

   logic clk;
   logic reset;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;

   // DUT A
   logic        cmd_valid_a, cmd_ready_a, out_ready_a;
   logic [9:0]  cmd_base_a, ram_address_a;
   logic [10:0] cmd_count_a;
   logic        ram_clken_a, ram_read_en_a, ram_write_en_a;
   logic [3:0]  ram_byte_en_a;
   logic [31:0] ram_write_data_a, ram_read_data_a, out_data_a;
   logic        out_valid_a, out_last_a, busy_a, done_a;

   // DUT B
   logic        cmd_valid_b, cmd_ready_b, out_ready_b;
   logic [9:0]  cmd_base_b, ram_address_b;
   logic [10:0] cmd_count_b;
   logic        ram_clken_b, ram_read_en_b, ram_write_en_b;
   logic [3:0]  ram_byte_en_b;
   logic [31:0] ram_write_data_b, ram_read_data_b, out_data_b;
   logic        out_valid_b, out_last_b, busy_b, done_b;

   ram_stream_reader #(.WIDTH(32), .ADDR_WIDTH(10), .LATENCY(1), .FIFO_DEPTH(2)) dut_a (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a), .cmd_base(cmd_base_a), .cmd_count(cmd_count_a),
      .ram_clken(ram_clken_a), .ram_read_en(ram_read_en_a), .ram_write_en(ram_write_en_a),
      .ram_address(ram_address_a), .ram_byte_en(ram_byte_en_a), .ram_write_data(ram_write_data_a),
      .ram_read_data(ram_read_data_a),
      .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a), .out_last(out_last_a),
      .busy(busy_a), .done(done_a)
   );

   ram_stream_reader #(.WIDTH(32), .ADDR_WIDTH(10), .LATENCY(3), .FIFO_DEPTH(4)) dut_b (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_base(cmd_base_b), .cmd_count(cmd_count_b),
      .ram_clken(ram_clken_b), .ram_read_en(ram_read_en_b), .ram_write_en(ram_write_en_b),
      .ram_address(ram_address_b), .ram_byte_en(ram_byte_en_b), .ram_write_data(ram_write_data_b),
      .ram_read_data(ram_read_data_b),
      .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b), .out_last(out_last_b),
      .busy(busy_b), .done(done_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc++;

   // RAM models: data is the address; idle cycles return a poison pattern.
   logic [31:0] pipe_a;
   logic [31:0] pipe_b [3];
   always @(posedge clk) begin
      pipe_a    <= ram_read_en_a ? 32'(ram_address_a) : 32'hDEAD_BEEF;
      pipe_b[0] <= ram_read_en_b ? 32'(ram_address_b) : 32'hDEAD_BEEF;
      pipe_b[1] <= pipe_b[0];
      pipe_b[2] <= pipe_b[1];
   end
   assign ram_read_data_a = pipe_a;
   assign ram_read_data_b = pipe_b[2];

   // Stream monitor for DUT B.
   logic [32:0] got_q [$];
   int          acc_q [$];
   int          done_q [$];
   int          done_cnt_b = 0;
   int          hold_err = 0;
   int          max_occ = 0;
   int          max_fifo = 0;
   bit          hold_pending = 0;
   logic [32:0] hold_val;

   always @(negedge clk) begin
      if (reset) begin
         hold_pending = 0;
      end else begin
         if (hold_pending && (!out_valid_b || ({out_last_b, out_data_b} != hold_val))) hold_err++;
         hold_pending = out_valid_b && !out_ready_b;
         hold_val     = {out_last_b, out_data_b};
         if (out_valid_b && out_ready_b) got_q.push_back({out_last_b, out_data_b});
         if (cmd_valid_b && cmd_ready_b) acc_q.push_back(cyc);
         if (done_b) begin
            done_cnt_b++;
            done_q.push_back(cyc);
         end
         if (int'(dut_b.inflight) + int'(dut_b.fifo_cnt) > max_occ)
            max_occ = int'(dut_b.inflight) + int'(dut_b.fifo_cnt);
         if (int'(dut_b.fifo_cnt) > max_fifo) max_fifo = int'(dut_b.fifo_cnt);
      end
   end

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   task automatic issue_b(input int base, input int cnt, input bit keep);
      int n = 0;
      cmd_base_b  = 10'(base);
      cmd_count_b = 11'(cnt);
      cmd_valid_b = 1'b1;
      @(negedge clk);
      while (!cmd_ready_b && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("cmd_accept", 64'(cmd_ready_b), 64'(1));
      @(posedge clk); #1;
      if (!keep) cmd_valid_b = 1'b0;
   endtask

   task automatic wait_done_b(input string tag, input int target);
      int n = 0;
      while (done_cnt_b < target && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      check(tag, 64'(done_cnt_b >= target), 64'(1));
   endtask

   task automatic chk_stream(input string tag, input int idx0, input int base, input int n);
      logic [9:0] a;
      for (int i = 0; i < n; i++) begin
         a = 10'(base + i);
         if (idx0 + i < got_q.size()) begin
            check({tag, "_dat"}, 64'(got_q[idx0+i][31:0]), 64'(a));
            check({tag, "_last"}, 64'(got_q[idx0+i][32]), 64'(i == n - 1));
         end
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0] ea;
      int d0;
      int c;
      int lasts;
      reset = 1'b1;
      cmd_valid_a = 0; cmd_base_a = '0; cmd_count_a = '0; out_ready_a = 1'b1;
      cmd_valid_b = 0; cmd_base_b = '0; cmd_count_b = '0; out_ready_b = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_cmd_ready", 64'(cmd_ready_b), 64'(1));
      check("rst_out_valid", 64'(out_valid_b), 64'(0));
      check("rst_busy", 64'(busy_b), 64'(0));
      check("rst_done", 64'(done_a), 64'(0));
      check("rst_rd_en", 64'(ram_read_en_a), 64'(0));

      // A: base 5, count 4 -> 5,6,7,8 back to back, done one cycle after last
      @(posedge clk); #1;
      cmd_base_a = 10'd5; cmd_count_a = 11'd4; cmd_valid_a = 1'b1;
      @(negedge clk);
      check("a_cmd_ready", 64'(cmd_ready_a), 64'(1));
      @(posedge clk); #1 cmd_valid_a = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         check("a_rd_en", 64'(ram_read_en_a), 64'(k < 4));
         if (k < 4) check("a_addr", 64'(ram_address_a), 64'(5 + k));
         check("a_valid", 64'(out_valid_a), 64'(k >= 2 && k <= 5));
         if (k >= 2 && k <= 5) begin
            check("a_data", 64'(out_data_a), 64'(k + 3));
            check("a_last", 64'(out_last_a), 64'(k == 5));
         end
         check("a_done", 64'(done_a), 64'(k == 6));
         check("a_busy", 64'(busy_a), 64'(k <= 6));
      end

      // A: count 0 -> done next cycle, no reads, no data
      @(posedge clk); #1;
      cmd_base_a = 10'd3; cmd_count_a = 11'd0; cmd_valid_a = 1'b1;
      @(negedge clk);
      check("z_cmd_ready", 64'(cmd_ready_a), 64'(1));
      @(posedge clk); #1 cmd_valid_a = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("z_done", 64'(done_a), 64'(k == 0));
         check("z_rd_en", 64'(ram_read_en_a), 64'(0));
         check("z_valid", 64'(out_valid_a), 64'(0));
      end

      // B: address wrap 1022,1023,0,1
      @(posedge clk); #1;
      out_ready_b = 1'b1;
      issue_b(1022, 4, 0);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check("w_rd_en", 64'(ram_read_en_b), 64'(k < 4));
         ea = 10'(1022 + k);
         if (k < 4) check("w_addr", 64'(ram_address_b), 64'(ea));
         check("w_valid", 64'(out_valid_b), 64'(k >= 4 && k <= 7));
         if (k >= 4 && k <= 7) begin
            ea = 10'(1022 + k - 4);
            check("w_data", 64'(out_data_b), 64'(ea));
            check("w_last", 64'(out_last_b), 64'(k == 7));
         end
         check("w_done", 64'(done_b), 64'(k == 8));
      end

      // B: random backpressure with a 20-cycle stall
      @(posedge clk); #1;
      got_q.delete();
      max_occ = 0; max_fifo = 0; hold_err = 0;
      d0 = done_cnt_b;
      issue_b(100, 40, 0);
      c = 0;
      while (done_cnt_b == d0 && c < 3000) begin
         out_ready_b = (c >= 10 && c < 30) ? 1'b0 : 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         c++;
      end
      out_ready_b = 1'b1;
      check("bp_done", 64'(done_cnt_b != d0), 64'(1));
      check("bp_count", 64'(got_q.size()), 64'(40));
      chk_stream("bp", 0, 100, 40);
      check("bp_hold", 64'(hold_err), 64'(0));
      check("bp_occ_le4", 64'(max_occ <= 4), 64'(1));
      check("bp_fifo_le4", 64'(max_fifo <= 4), 64'(1));

      // B: reset in the middle of a 16-word command
      issue_b(200, 16, 0);
      repeat (5) begin @(posedge clk); #1; end
      reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      check("mr_cmd_ready", 64'(cmd_ready_b), 64'(1));
      check("mr_rd_en", 64'(ram_read_en_b), 64'(0));
      check("mr_addr", 64'(ram_address_b), 64'(0));
      check("mr_valid", 64'(out_valid_b), 64'(0));
      check("mr_data", 64'(out_data_b), 64'(0));
      check("mr_last", 64'(out_last_b), 64'(0));
      check("mr_busy", 64'(busy_b), 64'(0));
      check("mr_done", 64'(done_b), 64'(0));
      got_q.delete();
      @(posedge clk); #1;
      d0 = done_cnt_b;
      issue_b(0, 2, 0);
      wait_done_b("mr_fresh_done", d0 + 1);
      check("mr_count", 64'(got_q.size()), 64'(2));
      chk_stream("mr", 0, 0, 2);

      // B: back-to-back commands with cmd_valid held
      got_q.delete(); acc_q.delete(); done_q.delete();
      d0 = done_cnt_b;
      issue_b(10, 3, 1);
      issue_b(20, 2, 0);
      wait_done_b("bb_done", d0 + 2);
      check("bb_count", 64'(got_q.size()), 64'(5));
      chk_stream("bb1", 0, 10, 3);
      chk_stream("bb2", 3, 20, 2);
      lasts = 0;
      foreach (got_q[i]) if (got_q[i][32]) lasts++;
      check("bb_lasts", 64'(lasts), 64'(2));
      check("bb_acc_n", 64'(acc_q.size()), 64'(2));
      if (acc_q.size() == 2 && done_q.size() >= 1)
         check("bb_acc_after_done", 64'(acc_q[1]), 64'(done_q[0] + 1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
